// File: rtl/sram_sp_access_ctrl.sv
// Single-port SRAM access controller for the predictor tables: clears every set
// after reset, then arbitrates reads and a 1-entry buffered write onto the RW port.
module sram_sp_access_ctrl #(
  parameter int SETS      = 64,
  parameter int WAYS      = 8,
  parameter int DATA_W    = 6,
  parameter int WR_STARVE = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 io_rreq_valid,
  output logic                 io_rreq_ready,
  input  logic [$clog2(SETS)-1:0] io_rreq_bits_setIdx,
  output logic                 io_rresp_valid,
  output logic [DATA_W-1:0]    io_rresp_data_0,
  output logic [DATA_W-1:0]    io_rresp_data_1,
  output logic [DATA_W-1:0]    io_rresp_data_2,
  output logic [DATA_W-1:0]    io_rresp_data_3,
  output logic [DATA_W-1:0]    io_rresp_data_4,
  output logic [DATA_W-1:0]    io_rresp_data_5,
  output logic [DATA_W-1:0]    io_rresp_data_6,
  output logic [DATA_W-1:0]    io_rresp_data_7,
  input  logic                 io_wreq_valid,
  output logic                 io_wreq_ready,
  input  logic [$clog2(SETS)-1:0] io_wreq_bits_setIdx,
  input  logic [DATA_W-1:0]    io_wreq_bits_data_0,
  input  logic [DATA_W-1:0]    io_wreq_bits_data_1,
  input  logic [DATA_W-1:0]    io_wreq_bits_data_2,
  input  logic [DATA_W-1:0]    io_wreq_bits_data_3,
  input  logic [DATA_W-1:0]    io_wreq_bits_data_4,
  input  logic [DATA_W-1:0]    io_wreq_bits_data_5,
  input  logic [DATA_W-1:0]    io_wreq_bits_data_6,
  input  logic [DATA_W-1:0]    io_wreq_bits_data_7,
  input  logic [WAYS-1:0]      io_wreq_bits_waymask,
  output logic                 init_done,
  output logic                 sram_rreq_valid,
  output logic [$clog2(SETS)-1:0] sram_rreq_setIdx,
  output logic                 sram_wreq_valid,
  output logic [$clog2(SETS)-1:0] sram_wreq_setIdx,
  output logic [DATA_W-1:0]    sram_wreq_data_0,
  output logic [DATA_W-1:0]    sram_wreq_data_1,
  output logic [DATA_W-1:0]    sram_wreq_data_2,
  output logic [DATA_W-1:0]    sram_wreq_data_3,
  output logic [DATA_W-1:0]    sram_wreq_data_4,
  output logic [DATA_W-1:0]    sram_wreq_data_5,
  output logic [DATA_W-1:0]    sram_wreq_data_6,
  output logic [DATA_W-1:0]    sram_wreq_data_7,
  output logic [WAYS-1:0]      sram_wreq_waymask,
  input  logic [DATA_W-1:0]    sram_rdata_0,
  input  logic [DATA_W-1:0]    sram_rdata_1,
  input  logic [DATA_W-1:0]    sram_rdata_2,
  input  logic [DATA_W-1:0]    sram_rdata_3,
  input  logic [DATA_W-1:0]    sram_rdata_4,
  input  logic [DATA_W-1:0]    sram_rdata_5,
  input  logic [DATA_W-1:0]    sram_rdata_6,
  input  logic [DATA_W-1:0]    sram_rdata_7
);

  localparam int IDX_W = $clog2(SETS);
  localparam int ROW_W = WAYS * DATA_W;

  typedef enum logic {INIT, RUN} state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  init_cnt;
  logic              init_done_r;

  logic              wb_valid;
  logic [3:0]        starve_cnt;
  logic [IDX_W-1:0]  wb_set_p0;
  logic [ROW_W-1:0]  wb_data_p0;
  logic [WAYS-1:0]   wb_mask_p0;
  logic              rresp_vld_p1;

  logic              run;
  logic              force_wr;
  logic              rd_issue;
  logic              wr_issue;
  logic              wr_accept;
  logic [ROW_W-1:0]  wdata_in;
  logic [ROW_W-1:0]  wdata_out;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= 4'(WR_STARVE)) ? 4'(WR_STARVE) : v + 4'd1;
  endfunction

  assign wdata_in = {io_wreq_bits_data_7, io_wreq_bits_data_6, io_wreq_bits_data_5,
                     io_wreq_bits_data_4, io_wreq_bits_data_3, io_wreq_bits_data_2,
                     io_wreq_bits_data_1, io_wreq_bits_data_0};

  // A pending write to the set being read must land first, and a starved write
  // steals the port; either way the read stalls for that cycle.
  assign run       = (state == RUN);
  assign force_wr  = wb_valid & ((starve_cnt == 4'(WR_STARVE)) |
                                 (wb_set_p0 == io_rreq_bits_setIdx));
  assign rd_issue  = run & io_rreq_valid & ~force_wr;
  assign wr_issue  = run & wb_valid & ~rd_issue;
  assign wr_accept = io_wreq_valid & io_wreq_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= INIT;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (init_cnt == IDX_W'(SETS - 1)) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
  end

  always_comb begin
    io_rreq_ready     = 1'b0;
    io_wreq_ready     = 1'b0;
    sram_rreq_valid   = 1'b0;
    sram_wreq_valid   = 1'b0;
    sram_wreq_setIdx  = wb_set_p0;
    sram_wreq_waymask = wb_mask_p0;
    wdata_out         = wb_data_p0;
    case (state)
      INIT: begin
        // Sweep is held off while reset is asserted.
        sram_wreq_valid   = reset_n;
        sram_wreq_setIdx  = init_cnt;
        sram_wreq_waymask = '1;
        wdata_out         = '0;
      end
      RUN: begin
        io_rreq_ready   = ~force_wr;
        io_wreq_ready   = ~wb_valid | wr_issue;
        sram_rreq_valid = rd_issue;
        sram_wreq_valid = wr_issue;
      end
      default: ;
    endcase
  end

  assign sram_rreq_setIdx = io_rreq_bits_setIdx;
  assign sram_wreq_data_0 = wdata_out[0*DATA_W +: DATA_W];
  assign sram_wreq_data_1 = wdata_out[1*DATA_W +: DATA_W];
  assign sram_wreq_data_2 = wdata_out[2*DATA_W +: DATA_W];
  assign sram_wreq_data_3 = wdata_out[3*DATA_W +: DATA_W];
  assign sram_wreq_data_4 = wdata_out[4*DATA_W +: DATA_W];
  assign sram_wreq_data_5 = wdata_out[5*DATA_W +: DATA_W];
  assign sram_wreq_data_6 = wdata_out[6*DATA_W +: DATA_W];
  assign sram_wreq_data_7 = wdata_out[7*DATA_W +: DATA_W];

  // Stage p0: write buffer control and sweep counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      init_cnt    <= '0;
      init_done_r <= 1'b0;
      wb_valid    <= 1'b0;
      starve_cnt  <= 4'd0;
    end else begin
      if (state == INIT) begin
        init_cnt <= init_cnt + 1'b1;
        if (init_cnt == IDX_W'(SETS - 1)) init_done_r <= 1'b1;
      end
      if (wr_accept)     wb_valid <= 1'b1;
      else if (wr_issue) wb_valid <= 1'b0;
      if (wr_issue || !wb_valid) starve_cnt <= 4'd0;
      else                       starve_cnt <= sat_inc(starve_cnt);
    end
  end

  always_ff @(posedge clock) begin
    if (wr_accept) begin
      wb_set_p0  <= io_wreq_bits_setIdx;
      wb_data_p0 <= wdata_in;
      wb_mask_p0 <= io_wreq_bits_waymask;
    end
  end

  // Stage p1: read response, data comes straight from the wrapper
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rresp_vld_p1 <= 1'b0;
    else          rresp_vld_p1 <= rd_issue;
  end

  assign init_done       = init_done_r;
  assign io_rresp_valid  = rresp_vld_p1;
  assign io_rresp_data_0 = sram_rdata_0;
  assign io_rresp_data_1 = sram_rdata_1;
  assign io_rresp_data_2 = sram_rdata_2;
  assign io_rresp_data_3 = sram_rdata_3;
  assign io_rresp_data_4 = sram_rdata_4;
  assign io_rresp_data_5 = sram_rdata_5;
  assign io_rresp_data_6 = sram_rdata_6;
  assign io_rresp_data_7 = sram_rdata_7;

endmodule

// File: tb/tb_sram_sp_access_ctrl.sv
// Directed bench for sram_sp_access_ctrl with a behavioural SRAM wrapper model
// that returns read data one cycle after issue.
module tb_sram_sp_access_ctrl;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       rreq_valid;
  logic [5:0] rreq_set;
  logic       wreq_valid;
  logic [5:0] wreq_set;
  logic [5:0] wr_data [8];
  logic [7:0] wreq_mask;
  logic [5:0] rdata_q [8];

  wire        rreq_ready, wreq_ready, rresp_valid, init_done_o;
  wire        sram_rreq_valid, sram_wreq_valid;
  wire  [5:0] sr_set, sw_set;
  wire  [7:0] sw_mask;
  wire  [5:0] sw_data [8];
  wire  [5:0] rsp_data [8];

  int checks = 0;
  int errors = 0;

  logic [5:0] mem [64][8];
  logic       wr40_seen = 1'b0;

  always #5 clock = ~clock;

  sram_sp_access_ctrl #(.SETS(64), .WAYS(8), .DATA_W(6), .WR_STARVE(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .io_rreq_valid(rreq_valid), .io_rreq_ready(rreq_ready), .io_rreq_bits_setIdx(rreq_set),
    .io_rresp_valid(rresp_valid),
    .io_rresp_data_0(rsp_data[0]), .io_rresp_data_1(rsp_data[1]),
    .io_rresp_data_2(rsp_data[2]), .io_rresp_data_3(rsp_data[3]),
    .io_rresp_data_4(rsp_data[4]), .io_rresp_data_5(rsp_data[5]),
    .io_rresp_data_6(rsp_data[6]), .io_rresp_data_7(rsp_data[7]),
    .io_wreq_valid(wreq_valid), .io_wreq_ready(wreq_ready), .io_wreq_bits_setIdx(wreq_set),
    .io_wreq_bits_data_0(wr_data[0]), .io_wreq_bits_data_1(wr_data[1]),
    .io_wreq_bits_data_2(wr_data[2]), .io_wreq_bits_data_3(wr_data[3]),
    .io_wreq_bits_data_4(wr_data[4]), .io_wreq_bits_data_5(wr_data[5]),
    .io_wreq_bits_data_6(wr_data[6]), .io_wreq_bits_data_7(wr_data[7]),
    .io_wreq_bits_waymask(wreq_mask),
    .init_done(init_done_o),
    .sram_rreq_valid(sram_rreq_valid), .sram_rreq_setIdx(sr_set),
    .sram_wreq_valid(sram_wreq_valid), .sram_wreq_setIdx(sw_set),
    .sram_wreq_data_0(sw_data[0]), .sram_wreq_data_1(sw_data[1]),
    .sram_wreq_data_2(sw_data[2]), .sram_wreq_data_3(sw_data[3]),
    .sram_wreq_data_4(sw_data[4]), .sram_wreq_data_5(sw_data[5]),
    .sram_wreq_data_6(sw_data[6]), .sram_wreq_data_7(sw_data[7]),
    .sram_wreq_waymask(sw_mask),
    .sram_rdata_0(rdata_q[0]), .sram_rdata_1(rdata_q[1]),
    .sram_rdata_2(rdata_q[2]), .sram_rdata_3(rdata_q[3]),
    .sram_rdata_4(rdata_q[4]), .sram_rdata_5(rdata_q[5]),
    .sram_rdata_6(rdata_q[6]), .sram_rdata_7(rdata_q[7])
  );

  // SRAM wrapper model, preloaded with a non-zero pattern so the sweep is visible
  initial begin
    for (int s = 0; s < 64; s++)
      for (int w = 0; w < 8; w++) mem[s][w] = 6'h15;
    for (int w = 0; w < 8; w++) rdata_q[w] = 6'h15;
  end

  always @(posedge clock) begin
    if (sram_wreq_valid === 1'b1) begin
      for (int w = 0; w < 8; w++)
        if (sw_mask[w]) mem[sw_set][w] <= sw_data[w];
      if (sw_set == 6'd40 && sw_data[0] == 6'h3F) wr40_seen <= 1'b1;
    end
    if (sram_rreq_valid === 1'b1)
      for (int w = 0; w < 8; w++) rdata_q[w] <= mem[sr_set][w];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic set_wr(input logic v, input logic [5:0] s, input logic [5:0] d,
                        input logic [7:0] m);
    wreq_valid = v;
    wreq_set   = s;
    wreq_mask  = m;
    for (int w = 0; w < 8; w++) wr_data[w] = d;
  endtask

  task automatic sweep(input string tag);
    int good = 0;
    logic [5:0] dor;
    for (int i = 0; i < 64; i++) begin
      @(negedge clock);
      dor = '0;
      for (int w = 0; w < 8; w++) dor = dor | sw_data[w];
      if (sram_wreq_valid === 1'b1 && sw_set === 6'(i) && sw_mask === 8'hFF &&
          dor === 6'h00 && rreq_ready === 1'b0 && wreq_ready === 1'b0 &&
          init_done_o === 1'b0)
        good++;
      next_cyc();
    end
    chk(tag, good, 64);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int good;
    logic [5:0] ror;
    reset_n    = 1'b1;
    rreq_valid = 1'b0;
    rreq_set   = '0;
    set_wr(1'b0, 6'd0, 6'd0, 8'h00);
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_init_done", init_done_o, 0);
    chk("rst_rresp_valid", rresp_valid, 0);
    chk("rst_rreq_ready", rreq_ready, 0);
    chk("rst_wreq_ready", wreq_ready, 0);
    chk("rst_sram_wreq_valid", sram_wreq_valid, 0);
    chk("rst_sram_rreq_valid", sram_rreq_valid, 0);

    next_cyc();
    reset_n = 1'b1;
    sweep("sweep_first");

    // Read set 5 right after the sweep
    rreq_valid = 1'b1; rreq_set = 6'd5;
    @(negedge clock);
    chk("run_init_done", init_done_o, 1);
    chk("run_wreq_ready", wreq_ready, 1);
    chk("run_rreq_ready", rreq_ready, 1);
    chk("rd5_issue", sram_rreq_valid, 1);
    chk("rd5_set", sr_set, 5);
    chk("run_no_write", sram_wreq_valid, 0);
    next_cyc();
    rreq_valid = 1'b0;
    @(negedge clock);
    ror = '0;
    for (int w = 0; w < 8; w++) ror = ror | rsp_data[w];
    chk("rd5_resp_valid", rresp_valid, 1);
    chk("rd5_resp_zero", ror, 0);
    next_cyc();
    @(negedge clock);
    chk("rd5_resp_one_shot", rresp_valid, 0);

    // Write set 10 then read it: the read stalls one cycle behind the write
    next_cyc();
    set_wr(1'b1, 6'd10, 6'h3F, 8'h08);
    wr_data[3] = 6'h2A;
    rreq_set = 6'd10;
    @(negedge clock);
    chk("wr10_accept", wreq_ready, 1);
    chk("wr10_not_same_cycle", sram_wreq_valid, 0);
    next_cyc();
    wreq_valid = 1'b0;
    rreq_valid = 1'b1;
    @(negedge clock);
    chk("raw_rreq_ready", rreq_ready, 0);
    chk("raw_no_read", sram_rreq_valid, 0);
    chk("raw_wr_issue", sram_wreq_valid, 1);
    chk("raw_wr_set", sw_set, 10);
    chk("raw_wr_mask", sw_mask, 8'h08);
    chk("raw_wr_data3", sw_data[3], 6'h2A);
    next_cyc();
    @(negedge clock);
    chk("raw_rreq_ready2", rreq_ready, 1);
    chk("raw_rd_issue", sram_rreq_valid, 1);
    chk("raw_no_write2", sram_wreq_valid, 0);
    next_cyc();
    rreq_valid = 1'b0;
    @(negedge clock);
    chk("raw_resp_valid", rresp_valid, 1);
    chk("raw_resp_data3", rsp_data[3], 6'h2A);
    chk("raw_resp_data2", rsp_data[2], 6'h00);

    // Starvation: write to set 1 waits behind continuous reads of set 2
    next_cyc();
    set_wr(1'b1, 6'd1, 6'h11, 8'h01);
    rreq_set = 6'd2;
    @(negedge clock);
    chk("st_accept", wreq_ready, 1);
    next_cyc();
    wreq_valid = 1'b0;
    rreq_valid = 1'b1;
    good = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (rreq_ready === 1'b1 && sram_rreq_valid === 1'b1 && sram_wreq_valid === 1'b0)
        good++;
      next_cyc();
    end
    chk("st_wait_cycles", good, 4);
    @(negedge clock);
    chk("st_force_ready", rreq_ready, 0);
    chk("st_force_no_read", sram_rreq_valid, 0);
    chk("st_force_write", sram_wreq_valid, 1);
    chk("st_force_set", sw_set, 1);
    next_cyc();
    @(negedge clock);
    chk("st_read_resumes", sram_rreq_valid, 1);
    next_cyc();
    rreq_set = 6'd1;
    @(negedge clock);
    chk("st_rd1_issue", sram_rreq_valid, 1);
    next_cyc();
    rreq_valid = 1'b0;
    @(negedge clock);
    chk("st_rd1_data0", rsp_data[0], 6'h11);
    chk("st_rd1_data1", rsp_data[1], 6'h00);

    // Same-cycle read and write to set 7: read sees the old contents
    next_cyc();
    rreq_valid = 1'b1; rreq_set = 6'd7;
    set_wr(1'b1, 6'd7, 6'h07, 8'hFF);
    @(negedge clock);
    chk("sc_rreq_ready", rreq_ready, 1);
    chk("sc_wreq_ready", wreq_ready, 1);
    chk("sc_rd_issue", sram_rreq_valid, 1);
    chk("sc_no_write", sram_wreq_valid, 0);
    next_cyc();
    rreq_valid = 1'b0;
    wreq_valid = 1'b0;
    @(negedge clock);
    chk("sc_resp_valid", rresp_valid, 1);
    chk("sc_resp_old", rsp_data[0], 6'h00);
    chk("sc_wr_issue", sram_wreq_valid, 1);
    chk("sc_wr_set", sw_set, 7);
    chk("sc_wr_data6", sw_data[6], 6'h07);
    next_cyc();
    rreq_valid = 1'b1;
    @(negedge clock);
    chk("sc_rd2_issue", sram_rreq_valid, 1);
    next_cyc();
    rreq_valid = 1'b0;
    @(negedge clock);
    chk("sc_resp_new", rsp_data[5], 6'h07);

    // Back-to-back writes with no reads: one issue per cycle, ready held high
    next_cyc();
    rreq_set = 6'd0;
    good = 0;
    for (int i = 0; i < 5; i++) begin
      set_wr(i < 4, 6'(20 + i), 6'(i + 1), 8'hFF);
      @(negedge clock);
      if (wreq_ready === 1'b1 &&
          ((i == 0) ? (sram_wreq_valid === 1'b0)
                    : (sram_wreq_valid === 1'b1 && sw_set === 6'(19 + i))))
        good++;
      next_cyc();
    end
    chk("b2b_writes", good, 5);
    @(negedge clock);
    chk("b2b_drained", sram_wreq_valid, 0);

    // Reset while a write is buffered and a read response is in flight
    next_cyc();
    set_wr(1'b1, 6'd40, 6'h3F, 8'hFF);
    rreq_valid = 1'b1; rreq_set = 6'd41;
    @(negedge clock);
    chk("mr_rd_issue", sram_rreq_valid, 1);
    next_cyc();
    wreq_valid = 1'b0;
    rreq_valid = 1'b0;
    #1;
    chk("mr_wb_pending", sram_wreq_valid, 1);
    chk("mr_wb_set", sw_set, 40);
    chk("mr_resp_inflight", rresp_valid, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("mr_rresp_valid", rresp_valid, 0);
    chk("mr_sram_wreq_valid", sram_wreq_valid, 0);
    chk("mr_sram_rreq_valid", sram_rreq_valid, 0);
    chk("mr_init_done", init_done_o, 0);
    chk("mr_rreq_ready", rreq_ready, 0);
    chk("mr_wreq_ready", wreq_ready, 0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    sweep("sweep_restart");
    chk("mr_no_stale_write", wr40_seen, 0);
    @(negedge clock);
    chk("mr_init_done_again", init_done_o, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_sp_access_ctrl.md
# sram_sp_access_ctrl

Access controller for the 64-set × 8-way × 6-bit single-port SRAM wrapper used by the predictor tables.
- Arbitrates one read requester and one write requester onto the single RW port.
- Buffers writes in a 1-entry write buffer with read-after-write ordering and a starvation bound.
- After reset, sweeps every set to zero before accepting any traffic.
- Generates a read-response valid one cycle after each read issue.

## Interface
Parameters:
- SETS, 64, number of sets; index width is log2(SETS) = 6
- WAYS, 8, number of ways
- DATA_W, 6, bits per way
- WR_STARVE, 4, maximum cycles a buffered write may wait before it is forced; range 1..15

Ports:
- clock  in  1  sole clock
- reset_n  in  1  reset, asynchronous, active-low
- io_rreq_valid  in  1  read request
- io_rreq_ready  out  1  read accepted when valid & ready
- io_rreq_bits_setIdx  in  6  read set
- io_rresp_valid  out  1  read data valid
- io_rresp_data_0..7  out  6 each  read data per way; combinational pass-through of sram_rdata_N
- io_wreq_valid  in  1  write request
- io_wreq_ready  out  1  write accepted when valid & ready
- io_wreq_bits_setIdx  in  6  write set
- io_wreq_bits_data_0..7  in  6 each  write data per way
- io_wreq_bits_waymask  in  8  per-way write enable
- init_done  out  1  high once the post-reset sweep has completed
- sram_rreq_valid  out  1  read issue to the SRAM wrapper
- sram_rreq_setIdx  out  6  read set
- sram_wreq_valid  out  1  write issue to the SRAM wrapper
- sram_wreq_setIdx  out  6  write set
- sram_wreq_data_0..7  out  6 each  write data
- sram_wreq_waymask  out  8  write mask
- sram_rdata_0..7  in  6 each  wrapper read data; valid the cycle after the read issue

## Operation
- State machine states: INIT, RUN.
- Reset enters INIT with init_cnt = 0.
- INIT:
  - Each cycle: sram_wreq_valid = 1, sram_wreq_setIdx = init_cnt, all data = 0, waymask = 8'hFF.
  - init_cnt increments by 1.
  - At init_cnt == SETS-1, the state moves to RUN and init_done is registered high.
  - io_rreq_ready = io_wreq_ready = 0 throughout INIT.
- RUN, write buffer (wb_valid, wb_set, wb_data, wb_mask):
  - A write is accepted when io_wreq_valid & io_wreq_ready.
  - io_wreq_ready = ~wb_valid | wr_issue, so the buffer can refill in the same cycle it drains.
  - An accepted write appears on the SRAM port no earlier than the next cycle.
- RUN, force condition: force = wb_valid & (starve_cnt == WR_STARVE | wb_set == io_rreq_bits_setIdx).
  - The same-set term drains a pending write before any read of that set.
- RUN, read acceptance: io_rreq_ready = ~force. Reads issue directly: sram_rreq_valid = io_rreq_valid & io_rreq_ready.
- RUN, write issue: wr_issue = wb_valid & ~sram_rreq_valid. The SRAM port never sees read and write in the same cycle.
- Starvation counter (starve_cnt, 4 bits):
  - Cleared on wr_issue or when ~wb_valid.
  - Otherwise increments, saturating at WR_STARVE.
- Ordering:
  - A read and a write accepted in the same cycle: the read is ordered first and returns pre-write data.
  - A read accepted after a write returns the post-write data, guaranteed by force.
- Reset mid-operation: asynchronously clears everything and restarts INIT. Any in-flight response is dropped and io_rresp_valid goes to 0.

## Timing
- Reset values: io_rresp_valid = 0, init_done = 0, wb_valid = 0, starve_cnt = 0, io_rreq_ready = 0, io_wreq_ready = 0.
- During reset, sram_wreq_valid = 1 is not driven because the state is held; sram_* valids are 0 while reset_n = 0.
- Init sweep: exactly SETS cycles, beginning with the first clock edge after deassertion. io_*_ready first rises in cycle SETS.
- Read latency: issue in cycle t gives io_rresp_valid = 1 in cycle t+1 with data from sram_rdata. There is no backpressure on responses.
- Write latency: accepted in cycle t; issued in cycle t+1 at the earliest and t+1+WR_STARVE at the latest.
- Read throughput: 1 per cycle while no force is pending. A forced write costs the read exactly one stall cycle.

## Test plan
- Reset release:
  - init_done rises after 64 cycles.
  - sram_wreq_setIdx steps 0..63 with waymask FF and data 0.
  - Read of set 5 then returns all ways 0 one cycle later.
- Write then read, same set:
  - Write set 10 with data_3 = 6'h2A and mask 8'h08.
  - Next cycle, read set 10 → io_rreq_ready = 0 for one cycle, write issues, read issues the following cycle.
  - Response shows data_3 = 2A.
- Starvation:
  - Buffer a write to set 1, then hold reads of set 2 continuously.
  - The write issues after exactly WR_STARVE = 4 wait cycles; io_rreq_ready is 0 in that cycle.
- Same-cycle read and write, both to set 7:
  - Read is accepted and returns the old value.
  - The write issues the next cycle.
- Back-to-back writes, no reads:
  - io_wreq_ready stays 1 and one write issues per cycle.
- Reset asserted mid-stream with wb_valid = 1:
  - All outputs return to reset values immediately and the buffered write is never issued.
  - The init sweep restarts.
